// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone classic arbiter sharing one SRAM slave between the
// instruction-fetch (master 0) and data (master 1) ports. A master owns the
// slave for its whole bus cycle; simultaneous requests are resolved by
// round-robin using the index of the most recently released master.

module wb_sram_arbiter #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int sel_width  = data_width / 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                m_cyc,
    input  logic [1:0]                m_stb,
    input  logic [1:0]                m_we,
    input  logic [2*addr_width-1:0]   m_adr,
    input  logic [2*data_width-1:0]   m_datwr,
    input  logic [2*sel_width-1:0]    m_sel,
    output logic [1:0]                m_ack,
    output logic [data_width-1:0]     m_datrd,
    output logic                      s_cyc,
    output logic                      s_stb,
    output logic                      s_we,
    output logic [addr_width-1:0]     s_adr,
    output logic [data_width-1:0]     s_datwr,
    output logic [sel_width-1:0]      s_sel,
    input  logic                      s_ack,
    input  logic [data_width-1:0]     s_datrd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last;
    logic   last_next;
    logic   granted;
    logic   gnt_idx;

    // Read data needs no steering: whichever master is acked picks it up
    assign m_datrd = s_datrd;

    // Grant state and round-robin history; last resets to 1 so master 0 wins the first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // Grant selection, release handover and combinational routing of the owner to the slave
    always_comb begin
        state_next = state;
        last_next  = last;
        granted    = 1'b0;
        gnt_idx    = 1'b0;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_adr      = '0;
        s_datwr    = '0;
        s_sel      = '0;
        m_ack      = 2'b00;

        case (state)
            IDLE: begin
                if (m_cyc == 2'b11) begin
                    state_next = last ? GNT0 : GNT1;
                end else if (m_cyc[0]) begin
                    state_next = GNT0;
                end else if (m_cyc[1]) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                granted = 1'b1;
                gnt_idx = 1'b0;
                if (!m_cyc[0]) begin
                    last_next  = 1'b0;
                    state_next = m_cyc[1] ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                granted = 1'b1;
                gnt_idx = 1'b1;
                if (!m_cyc[1]) begin
                    last_next  = 1'b1;
                    state_next = m_cyc[0] ? GNT0 : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (granted) begin
            s_cyc   = m_cyc[gnt_idx];
            s_stb   = m_stb[gnt_idx];
            s_we    = m_we[gnt_idx];
            s_adr   = m_adr[int'(gnt_idx) * addr_width +: addr_width];
            s_datwr = m_datwr[int'(gnt_idx) * data_width +: data_width];
            s_sel   = m_sel[int'(gnt_idx) * sel_width +: sel_width];
            m_ack   = gnt_idx ? {s_ack, 1'b0} : {1'b0, s_ack};
        end
    end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Self-checking bench for wb_sram_arbiter: two scripted Wishbone masters, a
// single-cycle-ack SRAM slave, and a behavioural owner/round-robin model that
// predicts every slave-side and ack output each cycle.

module tb_wb_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      m_cyc;
    logic [1:0]      m_stb;
    logic [1:0]      m_we;
    logic [2*AW-1:0] m_adr;
    logic [2*DW-1:0] m_datwr;
    logic [2*SW-1:0] m_sel;
    logic [1:0]      m_ack;
    logic [DW-1:0]   m_datrd;
    logic            s_cyc;
    logic            s_stb;
    logic            s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_datwr;
    logic [SW-1:0]   s_sel;
    logic            s_ack;
    logic [DW-1:0]   s_datrd;

    wb_sram_arbiter #(.addr_width(AW), .data_width(DW), .sel_width(SW)) dut (
        .clock(clock), .reset(reset),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_datwr(m_datwr), .m_sel(m_sel), .m_ack(m_ack), .m_datrd(m_datrd),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_datwr(s_datwr), .s_sel(s_sel), .s_ack(s_ack), .s_datrd(s_datrd)
    );

    always #5 clock = ~clock;

    // SRAM slave: ack one cycle after cyc&stb, single-cycle ack, byte-selected writes
    logic [31:0] mem [256];
    always @(posedge clock) begin
        if (reset) begin
            s_ack   <= 1'b0;
            s_datrd <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            s_ack <= s_cyc && s_stb && !s_ack;
            if (s_cyc && s_stb && !s_ack) begin
                s_datrd <= mem[s_adr[9:2]];
                if (s_we)
                    for (int b = 0; b < 4; b++)
                        if (s_sel[b]) mem[s_adr[9:2]][b*8 +: 8] <= s_datwr[b*8 +: 8];
            end
        end
    end

    typedef struct packed {
        logic       we;
        logic [7:0] idx;
        logic [31:0] dat;
        logic [3:0] sel;
        logic       rel;
        logic [3:0] gap;
        logic       abort;
    } op_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cycle = 0;
    logic        reset_req = 1'b1;
    op_t         q0[$];
    op_t         q1[$];
    int          gap[2];
    int          age[2];
    bit          started[2];
    int          op_start[2];
    int          rel_cyc[2];
    int          ack_cyc[2];
    int          ack_lat[2];
    bit          drove[2];
    logic [1:0]  ack_seen;
    int          ack_order[$];
    int          mdl_owner;
    int          mdl_last;
    logic [31:0] ref_mem [256];
    bit          rd_valid;
    logic [31:0] rd_got;
    logic [31:0] rd_exp;
    logic [104:0] bus_obs;
    logic [104:0] bus_exp;

    function automatic op_t make_op(logic we, logic [7:0] idx, logic [31:0] dat,
                                    logic [3:0] sel, logic rel, logic [3:0] g, logic ab);
        op_t op;
        op.we = we; op.idx = idx; op.dat = dat; op.sel = sel;
        op.rel = rel; op.gap = g; op.abort = ab;
        return op;
    endfunction

    function automatic int qsize(int n);
        return (n == 0) ? q0.size() : q1.size();
    endfunction

    function automatic op_t qhead(int n);
        return (n == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(int n);
        if (n == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic push_op(int n, op_t op);
        if (n == 0) q0.push_back(op);
        else        q1.push_back(op);
    endtask

    function automatic int order_code();
        int c = 0;
        foreach (ack_order[i]) c = c * 10 + ack_order[i] + 1;
        return c;
    endfunction

    // Drive both masters just after the falling edge, then form observed and predicted bus
    task automatic step_begin();
        op_t op;
        int o;
        @(negedge clock);
        cycle++;
        reset = reset_req;
        for (int n = 0; n < 2; n++) begin
            drove[n] = 1'b0;
            if (gap[n] == 0 && qsize(n) > 0) begin
                op = qhead(n);
                m_cyc[n] = 1'b1;
                m_stb[n] = !op.abort;
                m_we[n]  = op.we;
                m_adr[n*AW +: AW]   = {22'b0, op.idx, 2'b00};
                m_datwr[n*DW +: DW] = op.dat;
                m_sel[n*SW +: SW]   = op.sel;
                drove[n] = 1'b1;
                if (!started[n]) begin
                    started[n]  = 1'b1;
                    op_start[n] = cycle;
                end
            end else begin
                if (gap[n] > 0) gap[n]--;
                m_cyc[n] = 1'b0;
                m_stb[n] = 1'b0;
                m_we[n]  = 1'($urandom);
                m_adr[n*AW +: AW]   = $urandom;
                m_datwr[n*DW +: DW] = $urandom;
                m_sel[n*SW +: SW]   = 4'($urandom);
            end
        end
        #1;
        bus_obs = {s_cyc, s_stb, s_we, s_adr, s_datwr, s_sel, m_ack, m_datrd};
        if (mdl_owner < 0) begin
            bus_exp = {3'b000, 32'h0, 32'h0, 4'h0, 2'b00, s_datrd};
        end else begin
            o = mdl_owner;
            bus_exp = {m_cyc[o], m_stb[o], m_we[o], m_adr[o*AW +: AW], m_datwr[o*DW +: DW],
                       m_sel[o*SW +: SW], (s_ack ? ((o == 0) ? 2'b01 : 2'b10) : 2'b00), s_datrd};
        end
    endtask

    // Masters react to acks and aborts; the ownership model advances on this cycle's inputs
    task automatic step_end();
        op_t op;
        ack_seen = 2'b00;
        rd_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (drove[n]) begin
                op = qhead(n);
                if (op.abort) begin
                    age[n]++;
                    if (age[n] >= 2) begin
                        age[n] = 0;
                        qpop(n);
                        started[n] = 1'b0;
                        gap[n] = 1;
                        rel_cyc[n] = cycle + 1;
                    end
                end else if (m_ack[n] === 1'b1) begin
                    ack_seen[n] = 1'b1;
                    ack_lat[n]  = cycle - op_start[n];
                    ack_cyc[n]  = cycle;
                    ack_order.push_back(n);
                    if (op.we) begin
                        for (int b = 0; b < 4; b++)
                            if (op.sel[b]) ref_mem[op.idx][b*8 +: 8] = op.dat[b*8 +: 8];
                    end else begin
                        rd_valid = 1'b1;
                        rd_got   = m_datrd;
                        rd_exp   = ref_mem[op.idx];
                    end
                    qpop(n);
                    started[n] = 1'b0;
                    if (op.rel || qsize(n) == 0) begin
                        gap[n] = (op.gap == 0) ? 1 : int'(op.gap);
                        rel_cyc[n] = cycle + 1;
                    end
                end
            end
        end
        if (reset) begin
            mdl_owner = -1;
            mdl_last  = 1;
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        end else if (mdl_owner < 0) begin
            if (m_cyc == 2'b11)  mdl_owner = 1 - mdl_last;
            else if (m_cyc[0])   mdl_owner = 0;
            else if (m_cyc[1])   mdl_owner = 1;
        end else if (!m_cyc[mdl_owner]) begin
            mdl_last  = mdl_owner;
            mdl_owner = m_cyc[1 - mdl_owner] ? 1 - mdl_owner : -1;
        end
    endtask

    task automatic do_reset();
        reset_req = 1'b1;
        step_begin();
        step_end();
        reset_req = 1'b0;
    endtask

    // Outputs held at zero while reset is asserted
    task automatic test_reset();
        repeat (2) @(negedge clock);
        mdl_owner = -1;
        mdl_last  = 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int c = 0; c < 3; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== '0) begin
                tests_failed++;
                $display("[TB] FAIL reset outputs: got %h expected 0", bus_obs);
            end
            step_end();
        end
        reset_req = 1'b0;
    endtask

    // Master 0 writes 0xDEADBEEF to 0x10 then reads it back
    task automatic test_write_read();
        int acks0 = 0;
        int acks1 = 0;
        push_op(0, make_op(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b1, 4'd1, 1'b0));
        push_op(0, make_op(1'b0, 8'h04, 32'h0, 4'hF, 1'b1, 4'd1, 1'b0));
        for (int c = 0; c < 14; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== bus_exp) begin
                tests_failed++;
                $display("[TB] FAIL write_read bus @%0d: got %h expected %h", cycle, bus_obs, bus_exp);
            end
            if (m_ack[1] !== 1'b0) acks1++;
            step_end();
            if (ack_seen[0]) begin
                acks0++;
                tests_run++;
                if (ack_lat[0] != 2) begin
                    tests_failed++;
                    $display("[TB] FAIL write_read ack latency: got %0d expected 2", ack_lat[0]);
                end
            end
            if (rd_valid) begin
                tests_run++;
                if (rd_got !== 32'hDEADBEEF) begin
                    tests_failed++;
                    $display("[TB] FAIL write_read readback: got %h expected deadbeef", rd_got);
                end
            end
        end
        tests_run++;
        if (acks0 != 2) begin
            tests_failed++;
            $display("[TB] FAIL write_read ack0 count: got %0d expected 2", acks0);
        end
        tests_run++;
        if (acks1 != 0) begin
            tests_failed++;
            $display("[TB] FAIL write_read ack1 cycles: got %0d expected 0", acks1);
        end
    endtask

    // Tie right after reset: master 0 first, master 1 straight after the release
    task automatic test_tie();
        do_reset();
        ack_order.delete();
        rel_cyc[0] = -1;
        push_op(0, make_op(1'b0, 8'h01, 32'h0, 4'hF, 1'b1, 4'd1, 1'b0));
        push_op(1, make_op(1'b0, 8'h02, 32'h0, 4'hF, 1'b1, 4'd1, 1'b0));
        for (int c = 0; c < 12; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== bus_exp) begin
                tests_failed++;
                $display("[TB] FAIL tie bus @%0d: got %h expected %h", cycle, bus_obs, bus_exp);
            end
            step_end();
        end
        tests_run++;
        if (order_code() != 12) begin
            tests_failed++;
            $display("[TB] FAIL tie grant order: got %0d expected 12", order_code());
        end
        tests_run++;
        if (ack_cyc[1] - rel_cyc[0] != 2) begin
            tests_failed++;
            $display("[TB] FAIL tie handover gap: got %0d expected 2", ack_cyc[1] - rel_cyc[0]);
        end
    endtask

    // Both masters keep requesting: grants must alternate
    task automatic test_alternate();
        ack_order.delete();
        for (int k = 0; k < 3; k++) begin
            push_op(0, make_op(1'($urandom), 8'(k), $urandom, 4'hF, 1'b1, 4'd1, 1'b0));
            push_op(1, make_op(1'($urandom), 8'(k + 8), $urandom, 4'hF, 1'b1, 4'd1, 1'b0));
        end
        for (int c = 0; c < 40; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== bus_exp) begin
                tests_failed++;
                $display("[TB] FAIL alternate bus @%0d: got %h expected %h", cycle, bus_obs, bus_exp);
            end
            step_end();
            if (rd_valid) begin
                tests_run++;
                if (rd_got !== rd_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL alternate read data: got %h expected %h", rd_got, rd_exp);
                end
            end
        end
        tests_run++;
        if (order_code() != 121212) begin
            tests_failed++;
            $display("[TB] FAIL alternate grant order: got %0d expected 121212", order_code());
        end
    endtask

    // Master 1 holds the bus across three reads while master 0 waits
    task automatic test_back_to_back();
        logic [31:0] words [3];
        for (int k = 0; k < 3; k++) begin
            words[k] = $urandom;
            push_op(0, make_op(1'b1, 8'(k), words[k], 4'hF, 1'b1, 4'd1, 1'b0));
        end
        for (int c = 0; c < 20; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== bus_exp) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back preload bus @%0d: got %h expected %h", cycle, bus_obs, bus_exp);
            end
            step_end();
        end
        ack_order.delete();
        for (int k = 0; k < 3; k++)
            push_op(1, make_op(1'b0, 8'(k), 32'h0, 4'hF, (k == 2), 4'd1, 1'b0));
        push_op(0, make_op(1'b0, 8'h03, 32'h0, 4'hF, 1'b1, 4'd1, 1'b0));
        for (int c = 0; c < 25; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== bus_exp) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back bus @%0d: got %h expected %h", cycle, bus_obs, bus_exp);
            end
            step_end();
            if (rd_valid && ack_seen[1]) begin
                tests_run++;
                if (rd_got !== words[ack_order.size() - 1]) begin
                    tests_failed++;
                    $display("[TB] FAIL back_to_back read data: got %h expected %h",
                             rd_got, words[ack_order.size() - 1]);
                end
            end
        end
        tests_run++;
        if (order_code() != 2221) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back grant order: got %0d expected 2221", order_code());
        end
    endtask

    // Reset while master 0 is strobing, then a tie must go to master 0
    task automatic test_reset_mid();
        bit fired = 1'b0;
        bit checked = 1'b0;
        ack_order.delete();
        push_op(0, make_op(1'b0, 8'h05, 32'h0, 4'hF, 1'b1, 4'd1, 1'b0));
        for (int c = 0; c < 16; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== bus_exp) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid bus @%0d: got %h expected %h", cycle, bus_obs, bus_exp);
            end
            if (fired && !checked) begin
                checked = 1'b1;
                tests_run++;
                if (s_cyc !== 1'b0 || m_ack !== 2'b00) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_mid idle: got s_cyc=%b m_ack=%b expected 0/00", s_cyc, m_ack);
                end
            end
            if (!fired && s_stb === 1'b1 && m_cyc[0]) begin
                fired = 1'b1;
                reset = 1'b1;
                push_op(1, make_op(1'b0, 8'h06, 32'h0, 4'hF, 1'b1, 4'd1, 1'b0));
            end
            step_end();
        end
        tests_run++;
        if (!fired || order_code() != 12) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid grant order: got %0d expected 12", order_code());
        end
    endtask

    // Master 0 abandons its cycle before any ack; master 1 follows from IDLE
    task automatic test_abort();
        int first_gnt1 = -1;
        int idle_chk = 0;
        ack_order.delete();
        rel_cyc[0] = -1;
        push_op(0, make_op(1'b0, 8'h07, 32'h0, 4'hF, 1'b1, 4'd1, 1'b1));
        push_op(1, make_op(1'b0, 8'h08, 32'h0, 4'hF, 1'b1, 4'd1, 1'b0));
        gap[1] = 3;
        for (int c = 0; c < 12; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== bus_exp) begin
                tests_failed++;
                $display("[TB] FAIL abort bus @%0d: got %h expected %h", cycle, bus_obs, bus_exp);
            end
            if (rel_cyc[0] > 0 && cycle == rel_cyc[0] + 1) begin
                idle_chk++;
                tests_run++;
                if (s_cyc !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL abort idle after release: got s_cyc=%b expected 0", s_cyc);
                end
            end
            if (s_stb === 1'b1 && first_gnt1 < 0) first_gnt1 = cycle;
            step_end();
        end
        tests_run++;
        if (first_gnt1 - op_start[1] != 1 || idle_chk != 1) begin
            tests_failed++;
            $display("[TB] FAIL abort grant latency: got %0d expected 1", first_gnt1 - op_start[1]);
        end
        tests_run++;
        if (order_code() != 2) begin
            tests_failed++;
            $display("[TB] FAIL abort ack order: got %0d expected 2", order_code());
        end
    endtask

    // Random traffic from both masters against the ownership model and reference memory
    task automatic test_random();
        int n_ops = 40;
        for (int n = 0; n < 2; n++) begin
            gap[n] = $urandom_range(0, 3);
            for (int k = 0; k < n_ops; k++)
                push_op(n, make_op(1'($urandom), 8'($urandom_range(0, 15)), $urandom,
                                   4'($urandom_range(1, 15)),
                                   (k == n_ops - 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                                   4'($urandom_range(1, 3)), ($urandom_range(0, 9) == 0)));
        end
        for (int c = 0; c < 3000 && (qsize(0) + qsize(1) + gap[0] + gap[1]) > 0; c++) begin
            step_begin();
            tests_run++;
            if (bus_obs !== bus_exp) begin
                tests_failed++;
                $display("[TB] FAIL random bus @%0d: got %h expected %h", cycle, bus_obs, bus_exp);
            end
            step_end();
            if (rd_valid) begin
                tests_run++;
                if (rd_got !== rd_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL random read data: got %h expected %h", rd_got, rd_exp);
                end
            end
        end
        tests_run++;
        if (qsize(0) + qsize(1) != 0) begin
            tests_failed++;
            $display("[TB] FAIL random completion: got %0d ops left expected 0", qsize(0) + qsize(1));
        end
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            gap[n] = 0; age[n] = 0; started[n] = 1'b0; op_start[n] = 0;
            rel_cyc[n] = -1; ack_cyc[n] = 0; ack_lat[n] = 0; drove[n] = 1'b0;
        end
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        m_adr = '0; m_datwr = '0; m_sel = '0;
        mdl_owner = -1;
        mdl_last  = 1;
        test_reset();
        test_write_read();
        test_tie();
        test_alternate();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_sram_arbiter.md
# wb_sram_arbiter

Two-master Wishbone classic arbiter that shares one `wb_sram` slave between the copperv instruction-fetch and data ports. It sits between the core's two bus masters and the SRAM. It grants the slave to one master for the whole of that master's bus cycle (`cyc` high), breaks ties round-robin, and routes `ack` only to the granted master. Read data is broadcast to both masters.

## Interface
- `addr_width`, 32, address width of each master and of the slave
- `data_width`, 32, data width
- `sel_width`, data_width/8, byte-select width
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `m_cyc`  in  2  per-master cycle request; bit n belongs to master n
- `m_stb`  in  2  per-master strobe
- `m_we`  in  2  per-master write enable
- `m_adr`  in  2*addr_width  master n address in bits [n*addr_width +: addr_width]
- `m_datwr`  in  2*data_width  master n write data, same packing
- `m_sel`  in  2*sel_width  master n byte selects, same packing
- `m_ack`  out  2  ack to master n; only the granted bit can be 1
- `m_datrd`  out  data_width  equals `s_datrd`, shared by both masters
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to slave
- `s_adr`  out  addr_width  to slave
- `s_datwr`  out  data_width  to slave
- `s_sel`  out  sel_width  to slave
- `s_ack`  in  1  from slave
- `s_datrd`  in  data_width  from slave

## Operation
- States:
  - IDLE: no grant. `s_cyc`, `s_stb`, `s_we`, `s_adr`, `s_datwr` and `s_sel` are driven 0. `m_ack` is 0.
  - GNT0 and GNT1: the granted master's `cyc`, `stb`, `we`, `adr`, `datwr` and `sel` pass combinationally to the `s_*` outputs. `m_ack[n] = s_ack`. The other `m_ack` bit is 0.
- Register `last` holds the index of the most recently released master. It resets to 1, so master 0 wins the first tie.
- Transitions out of IDLE:
  - If exactly one `m_cyc` bit is set, go to that master's GNT state.
  - If both are set, go to GNT(!last).
  - If neither is set, stay in IDLE.
- Transitions out of GNTn:
  - While `m_cyc[n]` is 1, stay in GNTn. There is no preemption: master n keeps the grant across multiple `stb`/`ack` beats.
  - When `m_cyc[n]` is 0 (the release cycle), `s_cyc` is 0 combinationally and `last <= n`. Next state is GNT(other) if the other master's `cyc` is 1 in that cycle, otherwise IDLE.
- A non-granted master waits with `m_ack` at 0 and is never dropped. Its request stays pending until it is granted.
- A master may drop `cyc` without ever receiving `ack`. The arbiter releases normally.
- `reset` mid-transfer: state goes to IDLE and `last` to 1 on the next edge. All `s_*` outputs and `m_ack` are 0 from that edge on.

## Timing
- Arbitration latency: one cycle from `m_cyc` rising in IDLE to the `s_*` outputs carrying that master.
- Handover: zero idle cycles. The release cycle of master n is followed directly by GNT(other).
- Single read by master 0 against `wb_sram` (ack one cycle after `stb`&`cyc`, single-cycle ack):
  - c0: `m_cyc[0]=1`, state IDLE.
  - c1: GNT0, `s_stb=1`.
  - c2: `s_ack=1`, `m_ack[0]=1`, `m_datrd` valid.
  - c3: master drops `cyc`, which is the release cycle.
  - c4: IDLE.
- Output reset values: `m_ack=2'b00`; `s_cyc`, `s_stb`, `s_we`, `s_adr`, `s_datwr` and `s_sel` all 0.
- Combinational paths: master inputs to `s_*`, and `s_ack` to `m_ack`. The state and `last` registers are the only sequential elements.

## Test plan
- Reset, then master 0 writes 0xDEADBEEF to address 0x10 with `sel=4'hF`, then reads it back:
  - `m_ack[0]` pulses once per access, two cycles after `stb`.
  - `m_datrd=0xDEADBEEF`.
  - `m_ack[1]` stays 0 throughout.
- Both masters raise `cyc` in the same cycle right after reset:
  - master 0 is granted first.
  - master 1 is granted in the cycle after master 0's release, with no IDLE cycle in between.
- Both masters request continuously for 6 cycles each:
  - grants alternate 0,1,0,1.
  - neither master is granted twice in a row while the other is pending.
- Master 1 holds `cyc` across 3 back-to-back reads (addresses 0x0, 0x4, 0x8) while master 0 requests:
  - master 0 gets no `ack` until master 1 releases.
  - each of master 1's reads returns the stored word.
- Assert `reset` in the cycle `s_stb` is high for master 0:
  - next cycle: `s_cyc=0`, `m_ack=0`, state IDLE.
  - a tie right after reset grants master 0.
- Master 0 drops `cyc` before any `ack`:
  - the arbiter returns to IDLE.
  - a subsequent master 1 request is granted one cycle later.
